ram_read_arbiter: RTL

- Controller that owns one `ram_3port` instance (1 write port, 2 registered read ports).
- Shares the two read ports among NUM_REQ requesters using round-robin arbitration with a valid/ready handshake.
- Passes the single write port through to the RAM.
- Adds same-cycle write-to-read forwarding so a requester always sees the newest data.
- Sits between the MMU table-walk and lookup clients and the shared table RAM.

---
 rtl/mmu_pkg.sv | 17 +
 rtl/ram_3port.sv | 30 +++
 rtl/rr_pick2.sv | 53 +++++
 rtl/ram_read_arbiter.sv | 130 +++++++++++++
 4 files changed

// File: rtl/mmu_pkg.sv
// Shared MMU definitions: default table RAM geometry, requester index type
// and the wrap-around increment used by the round-robin pointer.
package mmu_pkg;

  localparam int NUM_REQ_DEF    = 4;
  localparam int ADDR_WIDTH_DEF = 6;
  localparam int DATA_WIDTH_DEF = 64;
  localparam int IDX_W_DEF      = $clog2(NUM_REQ_DEF);

  typedef logic [IDX_W_DEF-1:0] req_idx_t;

  // Cyclic increment that wraps at n, so unused indices above n-1 are never produced.
  function automatic int unsigned rr_wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/ram_3port.sv
// Simple dual-read, single-write table RAM. Both read ports are registered
// and return the old contents when a read and write hit the same address.
module ram_3port #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr1,
  input  logic [ADDR_WIDTH-1:0] rd_addr2,
  output logic [DATA_WIDTH-1:0] rd_data1,
  output logic [DATA_WIDTH-1:0] rd_data2
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port plus two read-first registered read ports.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data1 <= mem[rd_addr1];
    rd_data2 <= mem[rd_addr2];
  end

endmodule

// File: rtl/rr_pick2.sv
// Combinational cyclic priority picker returning up to two distinct winners,
// scanning req_valid starting at rr_ptr and wrapping at NUM_REQ.
module rr_pick2 import mmu_pkg::*; #(
  parameter  int NUM_REQ = NUM_REQ_DEF,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   g0,
  output logic [IDX_W-1:0]   g1,
  output logic               gnt0_v,
  output logic               gnt1_v
);

  localparam int             PAD   = 1 << IDX_W;
  localparam logic [IDX_W:0] NUM_W = (IDX_W + 1)'(NUM_REQ);

  logic [PAD-1:0]     valid_pad;
  logic [IDX_W-1:0]   cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0] cand_v;

  assign valid_pad = PAD'(req_valid);

  // Candidate k is the requester k steps after rr_ptr, wrapped at NUM_REQ.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      logic [IDX_W:0] sum;
      assign sum          = {1'b0, rr_ptr} + (IDX_W + 1)'(gi);
      assign cand_idx[gi] = (sum >= NUM_W) ? IDX_W'(sum - NUM_W) : IDX_W'(sum);
      assign cand_v[gi]   = valid_pad[cand_idx[gi]];
    end
  endgenerate

  // First valid candidate wins port 1, the second distinct one wins port 2.
  always_comb begin
    g0     = '0;
    g1     = '0;
    gnt0_v = 1'b0;
    gnt1_v = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (cand_v[k]) begin
        if (!gnt0_v) begin
          g0     = cand_idx[k];
          gnt0_v = 1'b1;
        end else if (!gnt1_v) begin
          g1     = cand_idx[k];
          gnt1_v = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ram_read_arbiter.sv
// Shares the two registered read ports of the table RAM among NUM_REQ
// requesters with round-robin arbitration, and forwards a same-edge write
// to any read of that address so responses always carry the newest data.
module ram_read_arbiter import mmu_pkg::*; #(
  parameter  int NUM_REQ    = NUM_REQ_DEF,
  parameter  int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
  localparam int IDX_W      = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [ADDR_WIDTH-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [NUM_REQ*DATA_WIDTH-1:0] resp_data
);

  logic [IDX_W-1:0]      rr_ptr_reg, rr_ptr_next, last_idx;
  logic [IDX_W-1:0]      g0, g1;
  logic                  gnt0_v, gnt1_v, gnt0, gnt1;
  logic [ADDR_WIDTH-1:0] req_addr_arr [NUM_REQ];
  logic [ADDR_WIDTH-1:0] rd_addr1, rd_addr2;
  logic [DATA_WIDTH-1:0] ram_rd_data1, ram_rd_data2;
  logic [DATA_WIDTH-1:0] port1_data, port2_data;

  logic                  p1_valid_reg, p2_valid_reg;
  logic [IDX_W-1:0]      p1_owner_reg, p2_owner_reg;
  logic                  fwd1_reg, fwd2_reg;
  logic [DATA_WIDTH-1:0] fwd_data_reg;

  rr_pick2 #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr_reg),
    .g0        (g0),
    .g1        (g1),
    .gnt0_v    (gnt0_v),
    .gnt1_v    (gnt1_v)
  );

  // No grants are issued while reset is held.
  assign gnt0 = gnt0_v & ~rst;
  assign gnt1 = gnt1_v & ~rst;

  // Unpack per-requester addresses so the winners can select them directly.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_addr
      assign req_addr_arr[gi] = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    end
  endgenerate

  assign rd_addr1 = req_addr_arr[g0];
  assign rd_addr2 = req_addr_arr[g1];

  // Decode the two winners into the one-hot-per-port ready vector.
  always_comb begin
    req_ready = '0;
    if (gnt0) req_ready[g0] = 1'b1;
    if (gnt1) req_ready[g1] = 1'b1;
  end

  // Advance the pointer past the last requester granted this cycle.
  always_comb begin
    last_idx    = gnt1 ? g1 : g0;
    rr_ptr_next = rr_ptr_reg;
    if (gnt0) begin
      rr_ptr_next = IDX_W'(rr_wrap_inc(32'(last_idx), NUM_REQ));
    end
  end

  ram_3port #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk      (clk),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr1 (rd_addr1),
    .rd_addr2 (rd_addr2),
    .rd_data1 (ram_rd_data1),
    .rd_data2 (ram_rd_data2)
  );

  // Track which requester owns each read port's result and whether the
  // RAM output must be replaced by the write that collided with the read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_reg   <= '0;
      p1_valid_reg <= 1'b0;
      p2_valid_reg <= 1'b0;
      p1_owner_reg <= '0;
      p2_owner_reg <= '0;
      fwd1_reg     <= 1'b0;
      fwd2_reg     <= 1'b0;
      fwd_data_reg <= '0;
    end else begin
      rr_ptr_reg   <= rr_ptr_next;
      p1_valid_reg <= gnt0;
      p2_valid_reg <= gnt1;
      p1_owner_reg <= g0;
      p2_owner_reg <= g1;
      fwd1_reg     <= gnt0 & wr_en & (wr_addr == rd_addr1);
      fwd2_reg     <= gnt1 & wr_en & (wr_addr == rd_addr2);
      fwd_data_reg <= wr_data;
    end
  end

  assign port1_data = fwd1_reg ? fwd_data_reg : ram_rd_data1;
  assign port2_data = fwd2_reg ? fwd_data_reg : ram_rd_data2;

  // Route each port's result to its owner; a pending result is dropped if
  // reset arrives in the response cycle.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_resp
      logic hit1, hit2;
      assign hit1 = p1_valid_reg & (p1_owner_reg == IDX_W'(gi));
      assign hit2 = p2_valid_reg & (p2_owner_reg == IDX_W'(gi));
      assign resp_valid[gi] = ~rst & (hit1 | hit2);
      assign resp_data[gi*DATA_WIDTH +: DATA_WIDTH] =
        rst  ? '0 :
        hit1 ? port1_data :
        hit2 ? port2_data : '0;
    end
  endgenerate

endmodule
